// File: rtl/regctl_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, writeback
// source codes, instruction field positions, FSM and op-class encodings.
// Optional feature macro: REGCTL_MUL_EN (enables the MUL instruction path).
package regctl_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ALU  = 4'd1;
  localparam logic [3:0] OP_LI   = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_SW   = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_MFHI = 4'd6;
  localparam logic [3:0] OP_MFLO = 4'd7;

  localparam logic [3:0] OUT_SEL_RAM   = 4'd0;
  localparam logic [3:0] OUT_SEL_ALU   = 4'd1;
  localparam logic [3:0] OUT_SEL_HI    = 4'd2;
  localparam logic [3:0] OUT_SEL_LO    = 4'd3;
  localparam logic [3:0] OUT_SEL_CONST = 4'd4;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS_MSB  = 8;
  localparam int unsigned RS_LSB  = 6;
  localparam int unsigned RT_MSB  = 5;
  localparam int unsigned RT_LSB  = 3;
  localparam int unsigned FN_MSB  = 2;
  localparam int unsigned FN_LSB  = 0;
  localparam int unsigned IMM_MSB = 8;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_MEM_WAIT,
    ST_WB
`ifdef REGCTL_MUL_EN
    , ST_MUL_WAIT
`endif
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_WB,
    CLS_LOAD,
    CLS_STORE,
    CLS_MUL,
    CLS_ILLEGAL
  } op_class_e;

  function automatic logic [15:0] sext9(input logic [8:0] imm);
    return {{7{imm[8]}}, imm};
  endfunction

endpackage

// File: rtl/regfile_seq_ctrl_if.sv
// Instruction valid/ready handshake between the issuing core and the sequencer.
interface regfile_seq_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/regctl_decode.sv
// Combinational instruction decoder: op class, register addresses, writeback
// source, sign-extended imm9 and illegal flag. With REGCTL_MUL_EN undefined
// opcode 5 decodes as illegal.
module regctl_decode
  import regctl_pkg::*;
(
  input  logic [15:0] instr,
  output op_class_e   op_class,
  output logic [2:0]  rs_loc,
  output logic [2:0]  rt_loc,
  output logic [2:0]  rd_loc,
  output logic [2:0]  alu_op,
  output logic [3:0]  out_sel,
  output logic [15:0] imm_sext,
  output logic        illegal
);

  logic [3:0] opcode;

  assign opcode   = instr[OPC_MSB:OPC_LSB];
  assign rd_loc   = instr[RD_MSB:RD_LSB];
  assign rs_loc   = instr[RS_MSB:RS_LSB];
  assign rt_loc   = instr[RT_MSB:RT_LSB];
  assign alu_op   = instr[FN_MSB:FN_LSB];
  assign imm_sext = sext9(instr[IMM_MSB:IMM_LSB]);
  assign illegal  = (op_class == CLS_ILLEGAL);

  // Opcode -> sequencing class and writeback source
  always_comb begin
    op_class = CLS_ILLEGAL;
    out_sel  = OUT_SEL_RAM;
    case (opcode)
      OP_NOP:  op_class = CLS_NOP;
      OP_ALU:  begin op_class = CLS_WB;   out_sel = OUT_SEL_ALU;   end
      OP_LI:   begin op_class = CLS_WB;   out_sel = OUT_SEL_CONST; end
      OP_LW:   begin op_class = CLS_LOAD; out_sel = OUT_SEL_RAM;   end
      OP_SW:   op_class = CLS_STORE;
`ifdef REGCTL_MUL_EN
      OP_MUL:  op_class = CLS_MUL;
`endif
      OP_MFHI: begin op_class = CLS_WB;   out_sel = OUT_SEL_HI;    end
      OP_MFLO: begin op_class = CLS_WB;   out_sel = OUT_SEL_LO;    end
      default: op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/regfile_seq_ctrl.sv
// Multi-cycle sequencer for the 8x16 register file: accepts one instruction
// per handshake, waits on RAM / multiplier, issues one write per instruction.
// Optional feature macro: REGCTL_MUL_EN (MUL instruction and MUL_WAIT state).
module regfile_seq_ctrl
  import regctl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned MUL_TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_seq_ctrl_if.slave        ibus,
  output logic [2:0]               rs_loc,
  output logic [2:0]               rt_loc,
  output logic [2:0]               rd_loc,
  output logic [3:0]               out_sel,
  output logic                     writesignal,
  output logic                     hilo_en,
  output logic [15:0]              constant_data,
  output logic [2:0]               alu_op,
  output logic                     mem_req,
  output logic                     mem_we,
  input  logic                     mem_ack,
  output logic                     mul_start,
  input  logic                     mul_done,
  output logic                     busy,
  output logic                     err
);

  localparam logic [7:0] MEM_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  op_class_e   op_class;
  logic        dec_illegal;

  // Decode from the latched instruction so addresses hold until the next accept
  regctl_decode u_decode (
    .instr    (instr_q),
    .op_class (op_class),
    .rs_loc   (rs_loc),
    .rt_loc   (rt_loc),
    .rd_loc   (rd_loc),
    .alu_op   (alu_op),
    .out_sel  (out_sel),
    .imm_sext (constant_data),
    .illegal  (dec_illegal)
  );

`ifdef REGCTL_MUL_EN
  localparam logic [7:0] MUL_LIMIT = 8'(MUL_TIMEOUT - 1);
`else
  // mul_done and MUL_TIMEOUT have no consumer in this build
  logic unused_mul;
  assign unused_mul = mul_done | (MUL_TIMEOUT == 0);
`endif

  assign busy = (state_q != ST_IDLE);
  assign err  = err_q;

  // State, instruction latch, wait counter and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state and strobe generation
  always_comb begin
    state_d          = state_q;
    instr_d          = instr_q;
    cnt_d            = cnt_q;
    err_d            = err_q;
    ibus.instr_ready = 1'b0;
    writesignal      = 1'b0;
    hilo_en          = 1'b0;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mul_start        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ibus.instr_ready = 1'b1;
        if (ibus.instr_valid) begin
          instr_d = ibus.instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          case (op_class)
            CLS_WB:    state_d = ST_WB;
            CLS_LOAD,
            CLS_STORE: begin
              cnt_d   = '0;
              state_d = ST_MEM_WAIT;
            end
`ifdef REGCTL_MUL_EN
            CLS_MUL: begin
              cnt_d     = '0;
              mul_start = 1'b1;
              state_d   = ST_MUL_WAIT;
            end
`endif
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_MEM_WAIT: begin
        mem_req = 1'b1;
        mem_we  = (op_class == CLS_STORE);
        // Ack is checked before the limit so a same-cycle ack completes normally
        if (mem_ack) begin
          state_d = (op_class == CLS_LOAD) ? ST_WB : ST_IDLE;
        end else if (cnt_q == MEM_LIMIT) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef REGCTL_MUL_EN
      ST_MUL_WAIT: begin
        if (mul_done) begin
          hilo_en = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == MUL_LIMIT) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      ST_WB: begin
        writesignal = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Directed bench for regfile_seq_ctrl; expectations adapt to REGCTL_MUL_EN.
module tb_regfile_seq_ctrl;
  import regctl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rs_loc, rt_loc, rd_loc, alu_op;
  logic [3:0]  out_sel;
  logic        writesignal, hilo_en, mem_req, mem_we, mem_ack;
  logic        mul_start, mul_done, busy, err;
  logic [15:0] constant_data;

  int n_cmp = 0;
  int n_err = 0;
  int ws_cnt = 0;
  int hl_cnt = 0;
  int nreq, nwe, ws0, hl0;

  regfile_seq_ctrl_if ibus ();

  regfile_seq_ctrl #(.MEM_TIMEOUT(16), .MUL_TIMEOUT(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ibus          (ibus),
    .rs_loc        (rs_loc),
    .rt_loc        (rt_loc),
    .rd_loc        (rd_loc),
    .out_sel       (out_sel),
    .writesignal   (writesignal),
    .hilo_en       (hilo_en),
    .constant_data (constant_data),
    .alu_op        (alu_op),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_ack       (mem_ack),
    .mul_start     (mul_start),
    .mul_done      (mul_done),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Count strobe cycles away from the active edge
  always @(negedge clk) begin
    if (writesignal === 1'b1) ws_cnt++;
    if (hilo_en === 1'b1) hl_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [15:0] w);
    ibus.instr       = w;
    ibus.instr_valid = 1'b1;
    tick();
    ibus.instr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ibus.instr_valid = 1'b0; ibus.instr = '0;
    mem_ack = 1'b0; mul_done = 1'b0;
    tick(); tick();
    // Reset state
    check("rst_ready", 16'(ibus.instr_ready), 16'h1);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_err", 16'(err), 16'h0);
    check("rst_ws", 16'(writesignal), 16'h0);
    check("rst_memreq", 16'(mem_req), 16'h0);
    check("rst_outsel", 16'(out_sel), 16'h0);
    check("rst_const", constant_data, 16'h0);
    check("rst_rd", 16'(rd_loc), 16'h0);
    rst = 1'b0;
    tick();

    // ALU 0x1253
    ws0 = ws_cnt;
    accept(16'h1253);
    check("alu_c1_ws", 16'(writesignal), 16'h0);
    check("alu_c1_ready", 16'(ibus.instr_ready), 16'h0);
    check("alu_outsel", 16'(out_sel), 16'h1);
    check("alu_rd", 16'(rd_loc), 16'h1);
    check("alu_rs", 16'(rs_loc), 16'h1);
    check("alu_rt", 16'(rt_loc), 16'h2);
    check("alu_op", 16'(alu_op), 16'h3);
    tick();
    check("alu_c2_ws", 16'(writesignal), 16'h1);
    check("alu_c2_ready", 16'(ibus.instr_ready), 16'h0);
    tick();
    check("alu_c3_ws", 16'(writesignal), 16'h0);
    check("alu_c3_ready", 16'(ibus.instr_ready), 16'h1);
    check("alu_ws_count", 16'(ws_cnt - ws0), 16'h1);

    // LI rd=3 imm9=0x1FF
    ws0 = ws_cnt;
    accept(16'h27FF);
    check("li_const", constant_data, 16'hFFFF);
    check("li_outsel", 16'(out_sel), 16'h4);
    check("li_rd", 16'(rd_loc), 16'h3);
    tick();
    check("li_ws", 16'(writesignal), 16'h1);
    tick();
    check("li_ws_count", 16'(ws_cnt - ws0), 16'h1);

    // LW rd=2 rs=5, ack on 5th wait cycle
    ws0 = ws_cnt;
    nreq = 0; nwe = 0;
    accept(16'h3540);
    check("lw_c1_memreq", 16'(mem_req), 16'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_req) nreq++;
      if (mem_we) nwe++;
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("lw_req_cycles", 16'(nreq), 16'd5);
    check("lw_we_cycles", 16'(nwe), 16'd0);
    check("lw_wb_ws", 16'(writesignal), 16'h1);
    check("lw_wb_memreq", 16'(mem_req), 16'h0);
    check("lw_outsel", 16'(out_sel), 16'h0);
    check("lw_rd", 16'(rd_loc), 16'h2);
    tick();
    check("lw_ready", 16'(ibus.instr_ready), 16'h1);
    check("lw_ws_count", 16'(ws_cnt - ws0), 16'h1);

    // Ack outside a wait state is ignored
    ws0 = ws_cnt;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    check("stray_ack_busy", 16'(busy), 16'h0);
    check("stray_ack_ws", 16'(ws_cnt - ws0), 16'h0);

    // LW with ack on the limit cycle: ack wins
    ws0 = ws_cnt;
    accept(16'h3540);
    for (int i = 0; i < 16; i++) tick();
    check("lim_memreq", 16'(mem_req), 16'h1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("lim_ws", 16'(writesignal), 16'h1);
    check("lim_err", 16'(err), 16'h0);
    tick();

    // SW with no ack -> timeout after 16 wait cycles
    ws0 = ws_cnt;
    nreq = 0; nwe = 0;
    accept(16'h4058);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!busy) break;
      if (mem_req) nreq++;
      if (mem_we) nwe++;
    end
    check("sw_req_cycles", 16'(nreq), 16'd16);
    check("sw_we_cycles", 16'(nwe), 16'd16);
    check("sw_err", 16'(err), 16'h1);
    check("sw_memreq", 16'(mem_req), 16'h0);
    check("sw_ready", 16'(ibus.instr_ready), 16'h1);
    check("sw_ws_count", 16'(ws_cnt - ws0), 16'h0);

    // Reset clears sticky err
    rst = 1'b1;
    #1;
    check("rst2_err", 16'(err), 16'h0);
    tick();
    rst = 1'b0;
    tick();

    // MUL rs=1 rt=2, then MFHI rd=4
    ws0 = ws_cnt; hl0 = hl_cnt;
    accept(16'h5050);
`ifdef REGCTL_MUL_EN
    check("mul_start_c1", 16'(mul_start), 16'h1);
    tick();
    check("mul_start_c2", 16'(mul_start), 16'h0);
    tick(); tick();
    mul_done = 1'b1;
    #1;
    check("mul_hilo", 16'(hilo_en), 16'h1);
    tick();
    mul_done = 1'b0;
    check("mul_ready", 16'(ibus.instr_ready), 16'h1);
    check("mul_hl_count", 16'(hl_cnt - hl0), 16'h1);
    check("mul_err", 16'(err), 16'h0);
`else
    check("mul_start_off", 16'(mul_start), 16'h0);
    tick();
    check("mul_err_off", 16'(err), 16'h1);
    check("mul_ready_off", 16'(ibus.instr_ready), 16'h1);
    check("mul_hl_off", 16'(hl_cnt - hl0), 16'h0);
`endif
    check("mul_ws_count", 16'(ws_cnt - ws0), 16'h0);
    ws0 = ws_cnt;
    accept(16'h6800);
    check("mfhi_outsel", 16'(out_sel), 16'h2);
    check("mfhi_rd", 16'(rd_loc), 16'h4);
    tick();
    check("mfhi_ws", 16'(writesignal), 16'h1);
    tick();
    check("mfhi_ws_count", 16'(ws_cnt - ws0), 16'h1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Illegal opcode 0xF
    ws0 = ws_cnt;
    accept(16'hF000);
    tick();
    check("ill_err", 16'(err), 16'h1);
    check("ill_ready", 16'(ibus.instr_ready), 16'h1);
    check("ill_ws_count", 16'(ws_cnt - ws0), 16'h0);

    // Reset mid LW wait aborts
    accept(16'h3540);
    tick(); tick();
    check("abort_pre_memreq", 16'(mem_req), 16'h1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_memreq", 16'(mem_req), 16'h0);
    check("abort_err", 16'(err), 16'h0);
    check("abort_ready", 16'(ibus.instr_ready), 16'h1);
    check("abort_busy", 16'(busy), 16'h0);
    check("abort_ws", 16'(writesignal), 16'h0);
    check("abort_hilo", 16'(hilo_en), 16'h0);
    check("abort_mulstart", 16'(mul_start), 16'h0);
    check("abort_rd", 16'(rd_loc), 16'h0);
    tick();
    rst = 1'b0;
    tick();
    check("post_busy", 16'(busy), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
